// File: rtl/override_tracker.sv
// override_tracker
//
// Purpose:
//   Keeps a free-running counter and a result register. The result register
//   can be left free for ordinary writes, bound to follow the counter
//   (TRACK), or pinned to a captured value (PIN). Writes that arrive while
//   the result is bound, or on the same edge as a binding request, are
//   rejected and flagged for one cycle on wr_blocked.
//
// Ports:
//   clk          - single clock, all state updates on its rising edge
//   rst_n        - asynchronous active-low reset
//   cnt_en       - increment the internal counter on this edge
//   assign_req   - bind result to the counter (to TRACK)
//   deassign_req - release any binding (to FREE)
//   pin_req      - pin result to pin_data (to PIN)
//   pin_data     - value captured into result with pin_req
//   wr_en        - ordinary write of wr_data into result
//   wr_data      - ordinary write value
//   counter      - internal counter register
//   result       - result register
//   state        - FREE=2'b00, TRACK=2'b01, PIN=2'b10
//   wr_blocked   - high for one cycle after a rejected write

module override_tracker #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             assign_req,
    input  logic             deassign_req,
    input  logic             pin_req,
    input  logic [WIDTH-1:0] pin_data,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] counter,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       state,
    output logic             wr_blocked
);

    localparam logic [1:0] STATE_FREE  = 2'b00;
    localparam logic [1:0] STATE_TRACK = 2'b01;
    localparam logic [1:0] STATE_PIN   = 2'b10;

    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic [1:0]       state_q,   state_d;
    logic             wr_blocked_q, wr_blocked_d;
    logic             anyReq;

    assign anyReq = deassign_req | pin_req | assign_req;

    // Counter runs independently of the binding state and wraps naturally.
    always_comb begin
        counter_d = counter_q;
        if (cnt_en) begin
            counter_d = counter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Request decoding against the pre-edge state, highest priority first:
    // deassign, then pin, then assign. With no request, the current state
    // decides what the result register does. A tracked result takes the
    // counter value from before the edge, so it lags the counter by one.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        if (deassign_req) begin
            state_d = STATE_FREE;
        end else if (pin_req) begin
            state_d  = STATE_PIN;
            result_d = pin_data;
        end else if (assign_req && state_q != STATE_TRACK) begin
            state_d = STATE_TRACK;
        end else begin
            case (state_q)
                STATE_TRACK: result_d = counter_q;
                STATE_FREE: begin
                    if (wr_en) begin
                        result_d = wr_data;
                    end
                end
                default: result_d = result_q;
            endcase
        end
    end

    // A write is rejected whenever it cannot land: the pre-edge state is
    // bound, or a binding request competes with it on the same edge.
    always_comb begin
        wr_blocked_d = wr_en & ((state_q != STATE_FREE) | anyReq);
    end

    // State registers with asynchronous reset back to FREE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q    <= '0;
            result_q     <= '0;
            state_q      <= STATE_FREE;
            wr_blocked_q <= 1'b0;
        end else begin
            counter_q    <= counter_d;
            result_q     <= result_d;
            state_q      <= state_d;
            wr_blocked_q <= wr_blocked_d;
        end
    end

    assign counter    = counter_q;
    assign result     = result_q;
    assign state      = state_q;
    assign wr_blocked = wr_blocked_q;

endmodule

// File: tb/tb_override_tracker.sv
// tb_override_tracker
//
// Directed-vector bench for override_tracker at WIDTH=8. Inputs change one
// time unit after a rising edge and outputs are sampled one time unit after
// the following rising edge.

module tb_override_tracker;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             cnt_en;
    logic             assign_req;
    logic             deassign_req;
    logic             pin_req;
    logic [WIDTH-1:0] pin_data;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] result;
    logic [1:0]       state;
    logic             wr_blocked;

    int vectorCount = 0;
    int missCount   = 0;

    override_tracker #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt_en       (cnt_en),
        .assign_req   (assign_req),
        .deassign_req (deassign_req),
        .pin_req      (pin_req),
        .pin_data     (pin_data),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .counter      (counter),
        .result       (result),
        .state        (state),
        .wr_blocked   (wr_blocked)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one set of request inputs, clock one edge, settle just after it.
    task automatic applyStimulus(input logic a, input logic d, input logic p,
                                 input logic [WIDTH-1:0] pd,
                                 input logic w, input logic [WIDTH-1:0] wd);
        assign_req   = a;
        deassign_req = d;
        pin_req      = p;
        pin_data     = pd;
        wr_en        = w;
        wr_data      = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0;
        cnt_en = 1'b0;
        assign_req = 1'b0;
        deassign_req = 1'b0;
        pin_req = 1'b0;
        pin_data = '0;
        wr_en = 1'b0;
        wr_data = '0;

        #12;
        checkOutput("reset counter", 32'(counter), 32'h0);
        checkOutput("reset result", 32'(result), 32'h0);
        checkOutput("reset state", 32'(state), 32'h0);
        checkOutput("reset wr_blocked", 32'(wr_blocked), 32'h0);

        // Release between edges, counting from here on.
        @(negedge clk);
        rst_n = 1'b1;
        cnt_en = 1'b1;
        repeat (4) idle();
        checkOutput("count to 4", 32'(counter), 32'd4);

        // Assign with counter at 4: next state TRACK, counter 5, result untouched.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("assign state", 32'(state), 32'h1);
        checkOutput("assign result hold", 32'(result), 32'h0);
        idle();
        checkOutput("track first", 32'(result), 32'd5);
        idle();
        checkOutput("track lag result", 32'(result), 32'd6);
        checkOutput("track lag counter", 32'(counter), 32'd7);

        // 92 more edges bring counter to 99 with result one behind.
        repeat (92) idle();
        checkOutput("counter 99", 32'(counter), 32'd99);
        checkOutput("result 98", 32'(result), 32'd98);

        // Deassign from TRACK: result freezes at 98.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("deassign state", 32'(state), 32'h0);
        checkOutput("deassign result", 32'(result), 32'd98);
        idle();
        checkOutput("free hold result", 32'(result), 32'd98);
        checkOutput("free counter runs", 32'(counter), 32'd101);

        // Pin 01, then two rejected writes.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00);
        checkOutput("pin state", 32'(state), 32'h2);
        checkOutput("pin result", 32'(result), 32'h01);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        checkOutput("pin wr1 result", 32'(result), 32'h01);
        checkOutput("pin wr1 blocked", 32'(wr_blocked), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        checkOutput("pin wr2 result", 32'(result), 32'h01);
        checkOutput("pin wr2 blocked", 32'(wr_blocked), 32'h1);
        idle();
        checkOutput("blocked clears", 32'(wr_blocked), 32'h0);

        // Deassign then a write one cycle later succeeds.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        checkOutput("unpin state", 32'(state), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
        checkOutput("free write result", 32'(result), 32'h00);
        checkOutput("free write blocked", 32'(wr_blocked), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5);
        checkOutput("free write A5", 32'(result), 32'hA5);

        // Write on the deassign edge is rejected.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h77);
        checkOutput("wr on deassign result", 32'(result), 32'h11);
        checkOutput("wr on deassign blocked", 32'(wr_blocked), 32'h1);

        // Walk the counter to FD, then track across the wrap.
        for (int i = 0; i < 300 && counter != 8'hFD; i++) idle();
        checkOutput("reach FD", 32'(counter), 32'hFD);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        idle();
        checkOutput("wrap result FE", 32'(result), 32'hFE);
        idle();
        checkOutput("wrap counter 00", 32'(counter), 32'h00);
        checkOutput("wrap result FF", 32'(result), 32'hFF);
        idle();
        checkOutput("wrap result 00", 32'(result), 32'h00);

        // All three requests in PIN: deassign wins.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00);
        checkOutput("triple req state", 32'(state), 32'h0);
        checkOutput("triple req result", 32'(result), 32'h3C);
        // Write alongside assign in FREE: assign wins, write flagged.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h55);
        checkOutput("wr+assign state", 32'(state), 32'h1);
        checkOutput("wr+assign blocked", 32'(wr_blocked), 32'h1);
        checkOutput("wr+assign result", 32'(result), 32'h3C);

        // Pin 3C, then assert reset between edges.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h00);
        checkOutput("pin 3C", 32'(result), 32'h3C);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst result", 32'(result), 32'h0);
        checkOutput("async rst state", 32'(state), 32'h0);
        checkOutput("async rst counter", 32'(counter), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        checkOutput("post rst state", 32'(state), 32'h0);
        checkOutput("post rst counter", 32'(counter), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h42);
        checkOutput("post rst write", 32'(result), 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
